// File: rtl/hp_rd_chunk_sched.sv
// Huge-page read scheduler: splits a job into 4 KB-safe chunks, drains completions, then notifies.
// Optional statistics counters are enabled with `define HP_RD_SCHED_STATS_EN.
module hp_rd_chunk_sched #(
    parameter int CHUNK_QW        = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic        hp_valid,
    input  logic [63:0] hp_addr,
    input  logic [18:0] hp_len_qw,
    output logic        hp_ack,
    output logic        read_chunk,
    output logic [63:0] huge_page_addr,
    output logic [8:0]  qwords_to_rd,
    input  logic        read_chunk_ack,
    input  logic        chunk_cpl,
    output logic        send_huge_page_rd_completed,
    input  logic        send_huge_page_rd_completed_ack,
    output logic        cpl_err
`ifdef HP_RD_SCHED_STATS_EN
    ,
    output logic [31:0] chunks_issued,
    output logic [31:0] jobs_done
`endif
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, UPDATE, DRAIN, NOTIFY, DONE
    } state_t;

    localparam logic [18:0] CHUNK19 = 19'(CHUNK_QW);
    localparam logic [8:0]  CHUNK9  = 9'(CHUNK_QW);
    localparam logic [4:0]  MAX_OUT = 5'(MAX_OUTSTANDING);

    state_t      state;
    state_t      state_nxt;
    logic [63:0] addr;
    logic [18:0] remaining;
    logic [4:0]  outstanding;
    logic [9:0]  to_bnd;
    logic [8:0]  cap;

    // Chunk length is derived from the registered address/remaining, so it
    // stays stable for as long as the ISSUE handshake is pending.
    always_comb begin
        to_bnd = 10'd512 - {1'b0, addr[11:3]};
        cap    = (remaining > CHUNK19) ? CHUNK9 : remaining[8:0];
        if ({1'b0, cap} > to_bnd) begin
            qwords_to_rd = to_bnd[8:0];
        end else begin
            qwords_to_rd = cap;
        end
    end

    assign huge_page_addr = addr;

    always_comb begin
        state_nxt                   = state;
        read_chunk                  = 1'b0;
        send_huge_page_rd_completed = 1'b0;
        hp_ack                      = 1'b0;
        unique case (state)
            IDLE: begin
                if (hp_valid) begin
                    state_nxt = (hp_len_qw != 19'd0) ? ISSUE : DRAIN;
                end
            end
            ISSUE: begin
                read_chunk = (outstanding < MAX_OUT);
                if (read_chunk && read_chunk_ack) begin
                    state_nxt = UPDATE;
                end
            end
            UPDATE: begin
                if (remaining != {10'd0, qwords_to_rd}) begin
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (outstanding == 5'd0) begin
                    state_nxt = NOTIFY;
                end
            end
            NOTIFY: begin
                send_huge_page_rd_completed = 1'b1;
                if (send_huge_page_rd_completed_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                hp_ack    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            addr        <= 64'd0;
            remaining   <= 19'd0;
            outstanding <= 5'd0;
            cpl_err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && hp_valid) begin
                addr      <= hp_addr;
                remaining <= hp_len_qw;
            end else if (state == UPDATE) begin
                addr      <= addr + {52'd0, qwords_to_rd, 3'b000};
                remaining <= remaining - {10'd0, qwords_to_rd};
            end
            // A completion coinciding with the issue increment cancels it out.
            if (chunk_cpl) begin
                if (state != UPDATE) begin
                    if (outstanding == 5'd0) begin
                        cpl_err <= 1'b1;
                    end else begin
                        outstanding <= outstanding - 5'd1;
                    end
                end
            end else if (state == UPDATE) begin
                outstanding <= outstanding + 5'd1;
            end
        end
    end

`ifdef HP_RD_SCHED_STATS_EN
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            chunks_issued <= 32'd0;
            jobs_done     <= 32'd0;
        end else begin
            if (state == UPDATE) begin
                chunks_issued <= chunks_issued + 32'd1;
            end
            if (state == DONE) begin
                jobs_done <= jobs_done + 32'd1;
            end
        end
    end
`endif

endmodule
